// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: capture, align, add, normalise/round.
// Round-to-nearest-even, subnormals flushed to zero, specials bypassed from the align stage.
module fp_addsub_pipe #(
    parameter int unsigned EXP_WIDTH      = 8,
    parameter int unsigned MANTISSA_WIDTH = 23
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     a_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     b_in,
    input  logic                                  op_in,
    input  logic                                  in_valid_in,
    output logic                                  in_ready_out,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     fpa_out,
    output logic [3:0]                            flags_out,
    output logic                                  out_valid_out,
    input  logic                                  out_ready_in
);
    localparam int unsigned W  = EXP_WIDTH + MANTISSA_WIDTH + 1;
    localparam int unsigned M  = MANTISSA_WIDTH;
    localparam int unsigned E  = EXP_WIDTH;
    localparam int unsigned SW = M + 4;
    localparam int unsigned LW = $clog2(SW) + 1;
    localparam int unsigned XW = E + LW + 2;
    localparam logic [E-1:0]  EXP_ONES = '1;
    localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'(EXP_ONES);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

    logic en;
    assign en           = ~out_valid_out | out_ready_in;
    assign in_ready_out = en;

    // Capture stage: b's sign is pre-inverted for subtraction.
    logic         v0;
    logic [W-1:0] a0, b0;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
        end else if (en) begin
            v0 <= in_valid_in;
            if (in_valid_in) begin
                a0 <= a_in;
                b0 <= {b_in[W-1] ^ op_in, b_in[W-2:0]};
            end
        end
    end

    // Align stage: classify, order by magnitude, shift the smaller significand.
    logic          sa, sb, za, zb, ia, ib, na, nb, a_big, eff_sub;
    logic [E-1:0]  ea, eb, e_big, e_small, d;
    logic [M-1:0]  fa, fb, f_big, f_small;
    logic [SW-1:0] ext_small, small_al, mask;
    logic          byp_c;
    logic [W-1:0]  byp_res_c;
    logic [3:0]    byp_flg_c;
    always_comb begin
        sa = a0[W-1];
        sb = b0[W-1];
        ea = a0[W-2:M];
        eb = b0[W-2:M];
        fa = a0[M-1:0];
        fb = b0[M-1:0];
        za = (ea == '0);
        zb = (eb == '0);
        ia = (ea == EXP_ONES) && (fa == '0);
        ib = (eb == EXP_ONES) && (fb == '0);
        na = (ea == EXP_ONES) && (fa != '0);
        nb = (eb == EXP_ONES) && (fb != '0);
        eff_sub = sa ^ sb;
        a_big   = {ea, fa} >= {eb, fb};
        e_big   = a_big ? ea : eb;
        e_small = a_big ? eb : ea;
        f_big   = a_big ? fa : fb;
        f_small = a_big ? fb : fa;
        d       = e_big - e_small;
        ext_small = {1'b1, f_small, 3'b000};
        mask      = '0;
        if (32'(d) >= 32'(SW - 1)) begin
            small_al = SW'(1);
        end else begin
            mask     = (SW'(1) << d) - SW'(1);
            small_al = (ext_small >> d) | SW'(|(ext_small & mask));
        end
        byp_c     = 1'b1;
        byp_res_c = '0;
        byp_flg_c = 4'b0000;
        if (na || nb) begin
            byp_res_c = QNAN;
        end else if (ia && ib && eff_sub) begin
            byp_res_c = QNAN;
            byp_flg_c = 4'b1000;
        end else if (ia) begin
            byp_res_c = a0;
        end else if (ib) begin
            byp_res_c = b0;
        end else if (za && zb) begin
            byp_res_c = {sa & sb, {(W-1){1'b0}}};
        end else if (za) begin
            byp_res_c = b0;
        end else if (zb) begin
            byp_res_c = a0;
        end else begin
            byp_c = 1'b0;
        end
    end

    logic          v1, byp1, sign1, sub1;
    logic [W-1:0]  res1;
    logic [3:0]    flg1;
    logic [E-1:0]  exp1;
    logic [SW-1:0] big1, small1;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1 <= 1'b0; byp1 <= 1'b0; sign1 <= 1'b0; sub1 <= 1'b0;
            res1 <= '0; flg1 <= '0; exp1 <= '0; big1 <= '0; small1 <= '0;
        end else if (en) begin
            v1     <= v0;
            byp1   <= byp_c;
            sign1  <= a_big ? sa : sb;
            sub1   <= eff_sub;
            res1   <= byp_res_c;
            flg1   <= byp_flg_c;
            exp1   <= e_big;
            big1   <= {1'b1, f_big, 3'b000};
            small1 <= small_al;
        end
    end

    // Add stage: larger magnitude first, so the difference is never negative.
    logic          v2, byp2, sign2;
    logic [W-1:0]  res2;
    logic [3:0]    flg2;
    logic [E-1:0]  exp2;
    logic [SW:0]   sum2;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v2 <= 1'b0; byp2 <= 1'b0; sign2 <= 1'b0;
            res2 <= '0; flg2 <= '0; exp2 <= '0; sum2 <= '0;
        end else if (en) begin
            v2    <= v1;
            byp2  <= byp1;
            sign2 <= sign1;
            res2  <= res1;
            flg2  <= flg1;
            exp2  <= exp1;
            sum2  <= sub1 ? ({1'b0, big1} - {1'b0, small1}) : ({1'b0, big1} + {1'b0, small1});
        end
    end

    // Normalise and round stage.
    logic [LW-1:0]          lzc;
    logic [SW-1:0]          norm;
    logic signed [XW-1:0]   exp_n, exp_f;
    logic [M:0]             mant;
    logic [M+1:0]           mant_r;
    logic [M-1:0]           frac;
    logic                   g, r, s, inc;
    logic [W-1:0]           res_c;
    logic [3:0]             flg_c;
    always_comb begin
        lzc = '0;
        for (int i = 0; i < int'(SW); i++) begin
            if (sum2[i]) lzc = LW'(int'(SW) - 1 - i);
        end
        if (sum2[SW]) begin
            norm  = {sum2[SW:2], sum2[1] | sum2[0]};
            exp_n = XW'(exp2) + XW'(1);
        end else begin
            norm  = sum2[SW-1:0] << lzc;
            exp_n = XW'(exp2) - XW'(lzc);
        end
        mant   = norm[SW-1:3];
        g      = norm[2];
        r      = norm[1];
        s      = norm[0];
        inc    = g & (r | s | mant[0]);
        mant_r = {1'b0, mant} + (M+2)'(inc);
        exp_f  = exp_n + XW'(mant_r[M+1]);
        frac   = mant_r[M+1] ? mant_r[M:1] : mant_r[M-1:0];
        if (byp2) begin
            res_c = res2;
            flg_c = flg2;
        end else if (sum2 == '0) begin
            res_c = '0;
            flg_c = 4'b0000;
        end else if (exp_f >= EXP_MAX) begin
            res_c = {sign2, EXP_ONES, {M{1'b0}}};
            flg_c = 4'b0101;
        end else if (exp_f < EXP_ONE) begin
            res_c = {sign2, {(W-1){1'b0}}};
            flg_c = 4'b0011;
        end else begin
            res_c = {sign2, exp_f[E-1:0], frac};
            flg_c = {3'b000, g | r | s};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_out <= 1'b0;
            fpa_out       <= '0;
            flags_out     <= '0;
        end else if (en) begin
            out_valid_out <= v2;
            if (v2) begin
                fpa_out   <= res_c;
                flags_out <= flg_c;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed single-precision vectors,
// latency, backpressure with hold checks, and mid-flight reset.
module tb_fp_addsub_pipe;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] a_in, b_in;
    logic        op_in, in_valid_in, in_ready_out;
    logic [31:0] fpa_out;
    logic [3:0]  flags_out;
    logic        out_valid_out, out_ready_in;

    fp_addsub_pipe #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .in_valid_in(in_valid_in), .in_ready_out(in_ready_out), .fpa_out(fpa_out),
        .flags_out(flags_out), .out_valid_out(out_valid_out), .out_ready_in(out_ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Present one op and hold it until accepted; optionally record its expected result.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] r, input logic [3:0] f, input bit track);
        bit acc = 1'b0;
        exp_t e;
        a_in = a; b_in = b; op_in = op; in_valid_in = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk_in);
            acc = in_ready_out;
            if (acc && track) begin
                e.res = r; e.flg = f;
                sb_q.push_back(e);
            end
            @(posedge clk_in); #1;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout a=%h b=%h", a, b);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk_in);
        repeat (6) @(posedge clk_in);
        #1;
        chk("drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rst_n_in = 1'b0; a_in = '0; b_in = '0; op_in = 1'b0;
        in_valid_in = 1'b0; out_ready_in = 1'b1;

        // Monitor: pop and compare on each handshake, check hold while stalled.
        fork
            begin
                bit          stalled = 1'b0;
                logic [31:0] held_res = '0;
                logic [3:0]  held_flg = '0;
                exp_t        e;
                forever begin
                    @(negedge clk_in);
                    if (rst_n_in && mon_en && out_valid_out) begin
                        if (stalled) begin
                            chk("stall_hold_res", 64'(fpa_out), 64'(held_res));
                            chk("stall_hold_flg", 64'(flags_out), 64'(held_flg));
                        end
                        if (out_ready_in) begin
                            stalled = 1'b0;
                            total++;
                            if (sb_q.size() == 0) begin
                                bad++;
                                $display("FAIL unexpected_output got=%h flags=%b", fpa_out, flags_out);
                            end else begin
                                e = sb_q.pop_front();
                                if (fpa_out !== e.res || flags_out !== e.flg) begin
                                    bad++;
                                    $display("FAIL result got=%h/%b want=%h/%b",
                                             fpa_out, flags_out, e.res, e.flg);
                                end
                            end
                        end else begin
                            stalled = 1'b1;
                            held_res = fpa_out;
                            held_flg = flags_out;
                        end
                    end else begin
                        stalled = 1'b0;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_valid", 64'(out_valid_out), 64'd0);
        chk("rst_fpa", 64'(fpa_out), 64'd0);
        chk("rst_flags", 64'(flags_out), 64'd0);
        rst_n_in = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready_out), 64'd1);

        // Latency: valid appears exactly after the third edge following accept.
        @(posedge clk_in); #1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
        in_valid_in = 1'b0;
        chk("lat_e0", 64'(out_valid_out), 64'd0);
        @(posedge clk_in); #1;
        chk("lat_e1", 64'(out_valid_out), 64'd0);
        @(posedge clk_in); #1;
        chk("lat_e2", 64'(out_valid_out), 64'd0);
        @(posedge clk_in); #1;
        chk("lat_e3", 64'(out_valid_out), 64'd1);
        drain();

        // Directed vectors, back to back.
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b1);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b1);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1'b1);
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 1'b1);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b1);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b1);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 1'b1);
        send(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 1'b1);
        in_valid_in = 1'b0;
        drain();

        // Backpressure: stream while the consumer toggles ready.
        fork
            begin
                send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
                send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b1);
                send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1'b1);
                send(32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000, 1'b1);
                send(32'h41200000, 32'h40A00000, 1'b0, 32'h41700000, 4'b0000, 1'b1);
                send(32'hC0000000, 32'h40000000, 1'b1, 32'hC0800000, 4'b0000, 1'b1);
                send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1'b1);
                send(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000, 1'b1);
                in_valid_in = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk_in); #1;
                    out_ready_in = 1'($urandom_range(0, 1));
                end
                out_ready_in = 1'b1;
            end
        join
        drain();

        // Reset with ops in flight discards them all.
        mon_en = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 4'b0, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h0, 4'b0, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h0, 4'b0, 1'b0);
        in_valid_in = 1'b0;
        @(posedge clk_in); #1;
        chk("pre_reset_valid", 64'(out_valid_out), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk("reset_valid_now", 64'(out_valid_out), 64'd0);
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_valid_held", 64'(out_valid_out), 64'd0);
        rst_n_in = 1'b1;
        mon_en = 1'b1;
        @(posedge clk_in); #1;
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b1);
        in_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("post_reset_e2", 64'(out_valid_out), 64'd0);
        @(posedge clk_in); #1;
        chk("post_reset_e3", 64'(out_valid_out), 64'd1);
        drain();
        repeat (10) @(posedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
